sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
// PURPOSE
//  Receiving end of the team's serial bit-stream link: collects bits from a
//  SISO/PISO shift chain into a WIDTH-bit parallel word.
//  - Presents each complete word on a valid/ready handshake.
//  - Flags overrun when the consumer stalls.
//  - Sits between a serial source (one bit per qualified clock) and parallel logic.
// PARAMETERS
//  WIDTH   4   bits per word, >= 2; bit counter width CW = $clog2(WIDTH+1)
// PORTS
//  clk        in   1      rising-edge clock, only clock
//  rst        in   1      synchronous reset, active-high
//  s_in       in   1      serial data bit
//  s_en       in   1      s_in is valid this cycle (bit strobe)
//  p_ready    in   1      consumer accepts p_data this cycle
//  p_data     out  WIDTH  assembled word, registered
//  p_valid    out  1      p_data holds a complete word
//  overrun    out  1      sticky: a bit arrived while a word was held
//  bit_cnt    out  CW     bits collected into the current partial word
//  parity_err out  1      present only with SIPO_RX_PARITY_EN
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - all outputs 0; state=COLLECT; shift reg cleared.
//   - Wins over every other input.
//   - Mid-word reset discards the partial word.
//  Bit order:
//   - MSB-first: shift_reg <= {shift_reg[WIDTH-2:0], s_in}.
//   - The first bit received ends in p_data[WIDTH-1].
//  FSM states:
//   - COLLECT: on s_en, shift and increment bit_cnt. On the WIDTH-th bit:
//     copy {shift_reg[WIDTH-2:0], s_in} to p_data, set bit_cnt=0.
//     Go to PARITY if the macro is set, else to FULL.
//   - FULL: p_valid=1 and p_data stable until handoff.
//     - p_ready=1, s_en=0: p_valid=0 next cycle -> COLLECT.
//     - p_ready=1, s_en=1: zero-bubble handoff. The new bit is accepted as bit 1
//       of the next word: bit_cnt=1, state COLLECT, p_valid=0.
//     - p_ready=0, s_en=1: bit dropped, overrun<=1, p_data unchanged.
//  Latency: p_valid rises the cycle after the posedge sampling the last bit.
//  s_en=0 in COLLECT: hold everything.
//  p_ready is ignored when p_valid=0.
//  Overrun clears only on reset.
// CONFIGURATION
//  SIPO_RX_PARITY_EN defined:
//   - Each frame is WIDTH data bits plus 1 even-parity bit.
//   - State PARITY: on s_en, parity_err <= ^{data,s_in}, then -> FULL.
//   - parity_err updates once per frame, held until the next frame's parity
//     bit, cleared by reset.
//   - p_valid is asserted even on error.
//   - s_en during PARITY never causes overrun.
//  Undefined:
//   - No PARITY state, no parity_err port.
//   - The frame is exactly WIDTH bits.
// TESTING (WIDTH=4, s_en=1 per bit unless stated)
//  1 Reset: rst=1 for 2 clk -> p_data=0, p_valid=0, overrun=0, bit_cnt=0.
//  2 Shift 1,0,1,0 with p_ready=0 -> after 4th edge p_valid=1, p_data=4'b1010,
//    bit_cnt=0.
//  3 Hold FULL, p_ready=0, shift 1 -> overrun=1, p_data stays 1010, p_valid=1.
//  4 FULL + p_ready=1 + s_in=1 -> next cycle p_valid=0, bit_cnt=1.
//    Then 1,1,1 -> p_data=4'b1111.
//  5 Shift 1,1, then rst=1 for 1 clk, then 0,0,1,1 -> p_data=4'b0011;
//    no stale bits, overrun=0.
//  6 [PARITY_EN] 1,0,1,1 + parity 1 -> parity_err=0.
//    1,0,1,1 + parity 0 -> parity_err=1, p_data=1011 both times.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: collects MSB-first bits into a WIDTH-bit word
// presented on a valid/ready handshake. Optional parity: define SIPO_RX_PARITY_EN.
module sipo_rx #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_en,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
`ifdef SIPO_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {COLLECT, PARITY, FULL} state_t;
`else
    typedef enum logic [1:0] {COLLECT, FULL} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            shift_reg <= '0;
            p_data    <= '0;
            p_valid   <= 1'b0;
            overrun   <= 1'b0;
            bit_cnt   <= '0;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (s_en) begin
                        shift_reg <= {shift_reg[WIDTH-2:0], s_in};
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            p_data  <= {shift_reg[WIDTH-2:0], s_in};
                            bit_cnt <= '0;
`ifdef SIPO_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= FULL;
                            p_valid <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: begin
                    if (s_en) begin
                        parity_err <= ^{p_data, s_in};
                        p_valid    <= 1'b1;
                        state      <= FULL;
                    end
                end
`endif
                FULL: begin
                    if (p_ready) begin
                        p_valid <= 1'b0;
                        state   <= COLLECT;
                        // A bit arriving on the handoff cycle starts the next word.
                        if (s_en) begin
                            shift_reg <= {shift_reg[WIDTH-2:0], s_in};
                            bit_cnt   <= CW'(1);
                        end
                    end else if (s_en) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (WIDTH=4); parity scenario runs
// only when SIPO_RX_PARITY_EN is defined.
module tb_sipo_rx;

    localparam int WIDTH = 4;
    localparam int CW = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             s_in = 1'b0;
    logic             s_en = 1'b0;
    logic             p_ready = 1'b0;
    logic [WIDTH-1:0] p_data;
    logic             p_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;
`ifdef SIPO_RX_PARITY_EN
    logic             parity_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    sipo_rx #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .s_in(s_in),
        .s_en(s_en),
        .p_ready(p_ready),
        .p_data(p_data),
        .p_valid(p_valid),
        .overrun(overrun),
        .bit_cnt(bit_cnt)
`ifdef SIPO_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_in = b;
        s_en = 1'b1;
        tick();
        s_en = 1'b0;
        s_in = 1'b0;
    endtask

    // Closes a frame: sends the parity bit when parity is compiled in.
    task automatic end_frame(input logic par);
`ifdef SIPO_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; s_en = 1'b1; s_in = 1'b1; p_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; s_en = 1'b0; s_in = 1'b0; p_ready = 1'b0;
        tests_run++;
        if (p_data !== 4'b0000) begin tests_failed++; $display("FAIL reset_p_data: got %b expected 0000", p_data); end
        tests_run++;
        if (p_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_p_valid: got %b expected 0", p_valid); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        tests_run++;
        if (bit_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
    endtask

    task automatic test_shift();
        p_ready = 1'b0;
        send_bit(1'b1);
        tests_run++;
        if (bit_cnt !== 3'd1) begin tests_failed++; $display("FAIL shift_cnt1: got %0d expected 1", bit_cnt); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tests_run++;
        if (p_data !== 4'b1010) begin tests_failed++; $display("FAIL shift_p_data: got %b expected 1010", p_data); end
        tests_run++;
        if (bit_cnt !== 3'd0) begin tests_failed++; $display("FAIL shift_bit_cnt: got %0d expected 0", bit_cnt); end
        end_frame(1'b0);
        tests_run++;
        if (p_valid !== 1'b1) begin tests_failed++; $display("FAIL shift_p_valid: got %b expected 1", p_valid); end
    endtask

    task automatic test_overrun();
        p_ready = 1'b0;
        send_bit(1'b1);
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
        tests_run++;
        if (p_data !== 4'b1010) begin tests_failed++; $display("FAIL overrun_p_data: got %b expected 1010", p_data); end
        tests_run++;
        if (p_valid !== 1'b1) begin tests_failed++; $display("FAIL overrun_p_valid: got %b expected 1", p_valid); end
    endtask

    task automatic test_back_to_back();
        p_ready = 1'b1;
        send_bit(1'b1);
        p_ready = 1'b0;
        tests_run++;
        if (p_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_p_valid_low: got %b expected 0", p_valid); end
        tests_run++;
        if (bit_cnt !== 3'd1) begin tests_failed++; $display("FAIL b2b_bit_cnt: got %0d expected 1", bit_cnt); end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        tests_run++;
        if (p_data !== 4'b1111) begin tests_failed++; $display("FAIL b2b_p_data: got %b expected 1111", p_data); end
        end_frame(1'b0);
        tests_run++;
        if (p_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_p_valid: got %b expected 1", p_valid); end
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_midword_reset();
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        tests_run++;
        if (p_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_p_valid: got %b expected 0", p_valid); end
        send_bit(1'b1);
        send_bit(1'b1);
        tick();
        tests_run++;
        if (bit_cnt !== 3'd2) begin tests_failed++; $display("FAIL idle_hold_cnt: got %0d expected 2", bit_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bit_cnt !== 3'd0) begin tests_failed++; $display("FAIL midrst_bit_cnt: got %0d expected 0", bit_cnt); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        end_frame(1'b0);
        tests_run++;
        if (p_data !== 4'b0011) begin tests_failed++; $display("FAIL midrst_p_data: got %b expected 0011", p_data); end
        tests_run++;
        if (p_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_p_valid: got %b expected 1", p_valid); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL midrst_overrun_end: got %b expected 0", overrun); end
    endtask

`ifdef SIPO_RX_PARITY_EN
    task automatic test_parity();
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        tests_run++;
        if (p_valid !== 1'b0) begin tests_failed++; $display("FAIL par_wait_valid: got %b expected 0", p_valid); end
        send_bit(1'b1);
        tests_run++;
        if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL par_good_err: got %b expected 0", parity_err); end
        tests_run++;
        if (p_data !== 4'b1011) begin tests_failed++; $display("FAIL par_good_data: got %b expected 1011", p_data); end
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0);
        tests_run++;
        if (parity_err !== 1'b1) begin tests_failed++; $display("FAIL par_bad_err: got %b expected 1", parity_err); end
        tests_run++;
        if (p_data !== 4'b1011) begin tests_failed++; $display("FAIL par_bad_data: got %b expected 1011", p_data); end
        tests_run++;
        if (p_valid !== 1'b1) begin tests_failed++; $display("FAIL par_bad_valid: got %b expected 1", p_valid); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL par_no_overrun: got %b expected 0", overrun); end
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_shift();
        test_overrun();
        test_back_to_back();
        test_midword_reset();
`ifdef SIPO_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
